window_sum_avg: RTL and testbench

- Parametrised multi-channel sliding-window summer/averager; successor to the fixed 8-channel, 32-tap shift-and-adder-tree block.
- Each of CH channels keeps a DEPTH-sample window fed by a streaming valid-qualified input, replacing load-at-reset data.
- Outputs the grand total over all channels and windows, plus a rounded, saturated, scaled result for LED or downstream display logic.
- Adds block (decimating) mode, synchronous clear, fill status and saturation flag.

---
 rtl/window_sum_avg.sv | 150 +++++++++++++++
 tb/tb_window_sum_avg.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/window_sum_avg.sv
// Multi-channel sliding/block window summer with rounded, saturated scaling.
// Two-stage pipeline: per-channel running sums, then a registered grand total.
module window_sum_avg #(
  parameter  int CH     = 8,
  parameter  int W      = 8,
  parameter  int DEPTH  = 32,
  parameter  int SHIFT  = 8,
  parameter  int OUT_W  = 8,
  localparam int ACC_W  = W + $clog2(DEPTH) + $clog2(CH),
  localparam int FILL_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              mode,
  input  logic              in_valid,
  input  logic [CH*W-1:0]   in_data,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_sum,
  output logic [OUT_W-1:0]  out_data,
  output logic              sat,
  output logic [FILL_W-1:0] fill
);

  localparam int CS_W  = W + $clog2(DEPTH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int RW    = (ACC_W > OUT_W) ? ACC_W + 1 : OUT_W + 1;
  localparam logic [FILL_W-1:0] FULL = FILL_W'(DEPTH);
  localparam logic [FILL_W-1:0] LAST = FILL_W'(DEPTH - 1);

  logic              r_mode;
  logic [PTR_W-1:0]  r_wptr;
  logic [FILL_W-1:0] r_fill;
  logic [CS_W-1:0]   r_chsum [CH];
  logic              r_v1;
  logic [W-1:0]      r_mem [CH][DEPTH];

  logic              w_clr;
  logic              w_beat;
  logic              w_full;
  logic              w_done;
  logic [FILL_W-1:0] w_fill_nxt;
  logic [CS_W-1:0]   w_new [CH];
  logic [CS_W-1:0]   w_old [CH];
  logic [CS_W-1:0]   w_cs_nxt [CH];
  logic [ACC_W-1:0]  w_tot;
  logic [RW-1:0]     w_rnd;
  logic [RW-1:0]     w_r;
  logic              w_sat;
  logic [OUT_W-1:0]  w_out;

  // A mode change behaves exactly like an explicit clear.
  assign w_clr  = clear | (mode != r_mode);
  assign w_beat = in_valid & ~w_clr;

  always_comb begin
    w_full     = (r_fill == FULL);
    w_done     = 1'b0;
    w_fill_nxt = r_fill;
    if (r_mode) begin
      w_done     = (r_fill == LAST);
      w_fill_nxt = w_done ? '0 : r_fill + FILL_W'(1);
    end else begin
      w_done     = (r_fill >= LAST);
      w_fill_nxt = w_full ? r_fill : r_fill + FILL_W'(1);
    end
  end

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      w_new[c] = CS_W'(in_data[c*W +: W]);
      w_old[c] = CS_W'(r_mem[c][r_wptr]);
      if (r_mode) begin
        w_cs_nxt[c] = (r_fill == '0) ? w_new[c]
                    : r_chsum[c] + w_new[c];
      end else begin
        w_cs_nxt[c] = r_chsum[c] + w_new[c]
                    - (w_full ? w_old[c] : '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_beat) begin
      for (int c = 0; c < CH; c++) begin
        r_mem[c][r_wptr] <= in_data[c*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode <= 1'b0;
      r_wptr <= '0;
      r_fill <= '0;
      r_v1   <= 1'b0;
      for (int c = 0; c < CH; c++) begin
        r_chsum[c] <= '0;
      end
    end else begin
      r_mode <= mode;
      r_v1   <= w_beat & w_done;
      if (w_clr) begin
        r_wptr <= '0;
        r_fill <= '0;
        for (int c = 0; c < CH; c++) begin
          r_chsum[c] <= '0;
        end
      end else if (w_beat) begin
        r_wptr <= r_wptr + PTR_W'(1);
        r_fill <= w_fill_nxt;
        for (int c = 0; c < CH; c++) begin
          r_chsum[c] <= w_cs_nxt[c];
        end
      end
    end
  end

  always_comb begin
    w_tot = '0;
    for (int c = 0; c < CH; c++) begin
      w_tot = w_tot + ACC_W'(r_chsum[c]);
    end
  end

  // Rounding is done one bit wider than the total so it never wraps.
  assign w_rnd = RW'(w_tot) + (RW'(1) << (SHIFT - 1));
  assign w_r   = w_rnd >> SHIFT;
  assign w_sat = |(w_r >> OUT_W);
  assign w_out = w_sat ? '1 : w_r[OUT_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_data  <= '0;
      sat       <= 1'b0;
    end else begin
      out_valid <= r_v1 & ~w_clr;
      if (r_v1 && !w_clr) begin
        out_sum  <= w_tot;
        out_data <= w_out;
        sat      <= w_sat;
      end
    end
  end

  assign fill = r_fill;

endmodule

// File: tb/tb_window_sum_avg.sv
// Randomised scoreboard bench for window_sum_avg.
// Two instances (SHIFT=8 and SHIFT=7) share stimulus so saturation is reachable.
module tb_window_sum_avg;

  localparam int CH     = 8;
  localparam int W      = 8;
  localparam int DEPTH  = 32;
  localparam int ACC_W  = 16;
  localparam int FILL_W = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear;
  logic              mode;
  logic              in_valid;
  logic [CH*W-1:0]   in_data;

  logic              v8, v7;
  logic [ACC_W-1:0]  sum8, sum7;
  logic [7:0]        d8, d7;
  logic              s8, s7;
  logic [FILL_W-1:0] f8, f7;

  window_sum_avg #(.CH(CH), .W(W), .DEPTH(DEPTH), .SHIFT(8), .OUT_W(8)) dut8 (
    .clk(clk), .rst(rst), .clear(clear), .mode(mode),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(v8), .out_sum(sum8), .out_data(d8), .sat(s8), .fill(f8)
  );

  window_sum_avg #(.CH(CH), .W(W), .DEPTH(DEPTH), .SHIFT(7), .OUT_W(8)) dut7 (
    .clk(clk), .rst(rst), .clear(clear), .mode(mode),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(v7), .out_sum(sum7), .out_data(d7), .sat(s7), .fill(f7)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int due;
    int sum;
    int d8;
    bit s8;
    int d7;
    bit s7;
  } exp_t;

  exp_t q[$];
  int   win[CH][$];
  bit   mreg;
  bit   armed = 1'b0;
  bit   md_cur;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   last_sum, last_d8, last_d7;

  function automatic void chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void scale(int total, int sh, output int d, output bit s);
    int r;
    r = (total + (1 << (sh - 1))) >> sh;
    s = (r > 255);
    d = s ? 255 : r;
  endfunction

  function automatic void clear_win();
    for (int c = 0; c < CH; c++) win[c].delete();
  endfunction

  function automatic void push_exp(int due);
    exp_t e;
    int   t;
    t = 0;
    for (int c = 0; c < CH; c++)
      foreach (win[c][i]) t += win[c][i];
    e.due = due;
    e.sum = t;
    scale(t, 8, e.d8, e.s8);
    scale(t, 7, e.d7, e.s7);
    q.push_back(e);
  endfunction

  // Window semantics straight from the behaviour rules, one edge at a time.
  function automatic void model(bit v, logic [CH*W-1:0] d, bit clr, bit md);
    if (clr || md != mreg) begin
      clear_win();
      while (q.size() > 0 && q[$].due == cyc) void'(q.pop_back());
    end else if (v) begin
      for (int c = 0; c < CH; c++) win[c].push_back(int'(d[c*W +: W]));
      if (!mreg) begin
        if (win[0].size() > DEPTH)
          for (int c = 0; c < CH; c++) void'(win[c].pop_front());
        if (win[0].size() == DEPTH) push_exp(cyc + 1);
      end else if (win[0].size() == DEPTH) begin
        push_exp(cyc + 1);
        clear_win();
      end
    end
    mreg = md;
  endfunction

  task automatic step(bit v, logic [CH*W-1:0] d, bit clr, bit md);
    in_valid = v;
    in_data  = d;
    clear    = clr;
    mode     = md;
    md_cur   = md;
    @(posedge clk);
    #1;
    model(v, d, clr, md);
    chk("fill8", int'(f8), win[0].size());
    chk("fill7", int'(f7), win[0].size());
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    chk("rst_valid", int'(v8), 0);
    chk("rst_sum", int'(sum8), 0);
    chk("rst_data", int'(d8), 0);
    chk("rst_sat", int'(s7), 0);
    chk("rst_fill", int'(f8), 0);
    q.delete();
    clear_win();
    mreg     = 1'b0;
    last_sum = 0;
    last_d8  = 0;
    last_d7  = 0;
    @(posedge clk);
    #1;
    rst   = 1'b1;
    armed = 1'b1;
  endtask

  function automatic logic [CH*W-1:0] fillv(int val);
    logic [CH*W-1:0] r;
    logic [7:0]      b;
    b = val[7:0];
    for (int c = 0; c < CH; c++) r[c*W +: W] = b;
    return r;
  endfunction

  function automatic logic [CH*W-1:0] rnd();
    logic [CH*W-1:0] r;
    for (int c = 0; c < CH; c++) r[c*W +: W] = 8'($urandom_range(0, 255));
    return r;
  endfunction

  always @(negedge clk) begin
    if (armed && rst) begin
      chk("valid_pair", int'(v7), int'(v8));
      if (v8) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_valid: got out_valid=1 expected 0 (t=%0t)", $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("latency", cyc, e.due);
          chk("sum8", int'(sum8), e.sum);
          chk("sum7", int'(sum7), e.sum);
          chk("data8", int'(d8), e.d8);
          chk("sat8", int'(s8), int'(e.s8));
          chk("data7", int'(d7), e.d7);
          chk("sat7", int'(s7), int'(e.s7));
          last_sum = e.sum;
          last_d8  = e.d8;
          last_d7  = e.d7;
        end
      end else begin
        chk("hold_sum", int'(sum8), last_sum);
        chk("hold_d8", int'(d8), last_d8);
        chk("hold_d7", int'(d7), last_d7);
      end
    end
  end

  initial begin
    logic [CH*W-1:0] d;
    rst      = 1'b1;
    clear    = 1'b0;
    mode     = 1'b0;
    md_cur   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    @(posedge clk);
    #1;
    do_reset();

    repeat (32) step(1, fillv(8'h80), 0, 0);
    d = fillv(8'h80);
    d[7:0] = 8'h00;
    repeat (2) step(1, d, 0, 0);
    repeat (3) step(0, '0, 0, 0);

    step(0, '0, 1, 0);
    d = '0;
    d[7:0] = 8'h0C;
    repeat (32) step(1, d, 0, 0);
    repeat (2) step(0, '0, 0, 0);

    step(0, '0, 1, 0);
    repeat (32) step(1, fillv(8'hFF), 0, 0);
    repeat (2) step(0, '0, 0, 0);

    step(0, '0, 1, 0);
    repeat (19) step(1, rnd(), 0, 0);
    step(1, rnd(), 1, 0);
    repeat (34) step(1, rnd(), 0, 0);

    repeat (200)
      step($urandom_range(0, 9) < 7, rnd(), $urandom_range(0, 49) == 0, 0);

    step(0, '0, 1, 0);
    repeat (10) step(1, rnd(), 0, 0);
    step(1, rnd(), 0, 1);
    repeat (64) step(1, fillv(8'h80), 0, 1);
    repeat (2) step(0, '0, 0, 1);

    repeat (150)
      step($urandom_range(0, 9) < 8, rnd(), $urandom_range(0, 59) == 0, 1);

    repeat (12) step(1, rnd(), 0, 1);
    do_reset();
    repeat (40) step(1, rnd(), 0, 0);

    repeat (300)
      step($urandom_range(0, 9) < 8, rnd(), $urandom_range(0, 69) == 0,
           ($urandom_range(0, 39) == 0) ? ~md_cur : md_cur);

    repeat (4) step(0, '0, 0, md_cur);
    chk("queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
